dmem_arbiter: RTL and testbench

Shares the single data memory between the pipeline MEM stage (CPU) and a DMA/loader master.
- Sits between the EX/MEM register outputs and the data memory.
- Raises cpu_stall to the hazard unit whenever the DMA holds the memory while the CPU needs it.
- Policy: CPU priority, opportunistic DMA use of idle slots, anti-starvation promotion of the DMA to bounded priority bursts.

---
 rtl/mips_arb_pkg.sv | 6 +
 rtl/arb_sat_counter.sv | 22 ++
 rtl/dmem_arbiter.sv | 75 +++++++
 tb/tb_dmem_arbiter.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/mips_arb_pkg.sv
// mips_arb_pkg: shared arbiter state encoding and default policy constants
package mips_arb_pkg;
  typedef enum logic {CPU_PRI, DMA_PRI} arbState_e;
  localparam int DEF_STARVE_LIMIT = 4;
  localparam int DEF_MAX_BURST = 8;
endpackage

// File: rtl/arb_sat_counter.sv
// arb_sat_counter: saturating up-counter with synchronous clear (clear wins)
//   clk, rst_n : clock, async active-low reset
//   inc, clr   : count up (stops at LIMIT) / clear to zero
//   count      : current value, $clog2(LIMIT+1) bits
//   atLimit    : count == LIMIT
module arb_sat_counter #(
  parameter int LIMIT = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         inc,
  input  logic                         clr,
  output logic [$clog2(LIMIT+1)-1:0]   count,
  output logic                         atLimit
);
  localparam int W = $clog2(LIMIT+1);
  assign atLimit = count == W'(LIMIT);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else if (clr) count <= '0;
    else if (inc && !atLimit) count <= count + W'(1);
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the data memory between the MEM stage and a DMA master
//   cpu_*  : MEM-stage request, zero-latency read data, stall to hazard unit
//   dma_*  : DMA request held until dma_gnt, registered read data + one-cycle valid
//   mem_*  : single data-memory port driven by the selected master
//   dma_pri: DMA currently owns priority (anti-starvation burst)
module dmem_arbiter
  import mips_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_rvalid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              dma_pri
);
  localparam int SW = $clog2(STARVE_LIMIT+1);
  localparam int BW = $clog2(MAX_BURST+1);
  arbState_e state, stateNext;
  logic [SW-1:0] starveCnt;
  logic [BW-1:0] burstCnt;
  logic starveFull, burstFull, dmaPri, dmaSel, blocked, toDma, toCpu;
  // rst_n gates the select so nothing is granted or written while reset is held
  always_comb begin
    dmaPri = state == DMA_PRI;
    dmaSel = rst_n && (dmaPri ? dma_req : dma_req && !cpu_req);
    blocked = !dmaPri && dma_req && cpu_req;
    toDma = blocked && (starveCnt == SW'(STARVE_LIMIT-1) || starveFull);
    toCpu = dmaPri && (!dma_req || (dmaSel && (burstCnt == BW'(MAX_BURST-1) || burstFull)));
    stateNext = toDma ? DMA_PRI : toCpu ? CPU_PRI : state;
  end
  assign dma_gnt = dmaSel;
  assign dma_pri = dmaPri;
  assign cpu_stall = rst_n && dmaPri && dma_req && cpu_req;
  assign mem_we = rst_n && (dmaSel ? dma_we : cpu_req && cpu_we);
  assign mem_addr = dmaSel ? dma_addr : cpu_addr;
  assign mem_wdata = dmaSel ? dma_wdata : cpu_wdata;
  assign cpu_rdata = mem_rdata;
  arb_sat_counter #(.LIMIT(STARVE_LIMIT)) starveCounter (
    .clk(clk), .rst_n(rst_n), .inc(blocked), .clr(dmaPri || dmaSel || !dma_req),
    .count(starveCnt), .atLimit(starveFull)
  );
  arb_sat_counter #(.LIMIT(MAX_BURST)) burstCounter (
    .clk(clk), .rst_n(rst_n), .inc(dmaPri && dmaSel), .clr(!dmaPri || toCpu),
    .count(burstCnt), .atLimit(burstFull)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= CPU_PRI;
      dma_rvalid <= 1'b0;
      dma_rdata <= '0;
    end else begin
      state <= stateNext;
      dma_rvalid <= dmaSel && !dma_we;
      if (dmaSel && !dma_we) dma_rdata <= mem_rdata;
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: randomized + directed check of dmem_arbiter against a policy-level model
module tb_dmem_arbiter;
  localparam int SL = 4, MB = 8;
  logic clk = 0, rst_n = 0;
  logic cpu_req = 0, cpu_we = 0, dma_req = 0, dma_we = 0;
  logic [31:0] cpu_addr = 0, cpu_wdata = 0, dma_addr = 0, dma_wdata = 0;
  logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;
  logic cpu_stall, dma_gnt, dma_rvalid, mem_we, dma_pri;
  logic [31:0] tbMem [256];
  logic [31:0] refMem [256];
  int checks = 0, errors = 0;
  bit refDma, expRv, lastStall, lastGnt;
  int waited, grants, stallSum;
  logic [31:0] expRd;
  always #5 clk = ~clk;
  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(SL), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .dma_req(dma_req),
    .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_gnt(dma_gnt),
    .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .dma_pri(dma_pri)
  );
  function automatic logic [31:0] pat(int i);
    return 32'hA5A5_0000 ^ 32'(i * 32'h0001_0203);
  endfunction
  assign mem_rdata = tbMem[mem_addr[7:0]];
  always @(posedge clk)
    if (!rst_n) for (int i = 0; i < 256; i++) tbMem[i] <= pat(i);
    else if (mem_we) tbMem[mem_addr[7:0]] <= mem_wdata;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic modelReset();
    refDma = 0; waited = 0; grants = 0; expRv = 0; expRd = 0; lastStall = 0; lastGnt = 0;
    for (int i = 0; i < 256; i++) refMem[i] = pat(i);
  endtask
  // One arbitration cycle: inputs already applied; check at negedge, advance model at posedge.
  task automatic cycle();
    bit g, st, we;
    logic [31:0] a, wd;
    @(negedge clk);
    g = refDma ? dma_req : (!cpu_req && dma_req);
    st = refDma && dma_req && cpu_req;
    we = g ? dma_we : (cpu_req && cpu_we);
    a = g ? dma_addr : cpu_addr;
    wd = g ? dma_wdata : cpu_wdata;
    chk("dma_gnt", 32'(dma_gnt), 32'(g));
    chk("cpu_stall", 32'(cpu_stall), 32'(st));
    chk("mem_we", 32'(mem_we), 32'(we));
    chk("mem_addr", mem_addr, a);
    if (we) chk("mem_wdata", mem_wdata, wd);
    chk("dma_pri", 32'(dma_pri), 32'(refDma));
    chk("dma_rvalid", 32'(dma_rvalid), 32'(expRv));
    chk("dma_rdata", dma_rdata, expRd);
    chk("cpu_rdata", cpu_rdata, refMem[a[7:0]]);
    stallSum += int'(cpu_stall);
    @(posedge clk);
    expRv = g && !dma_we;
    if (expRv) expRd = refMem[dma_addr[7:0]];
    if (we) refMem[a[7:0]] = wd;
    if (refDma) begin
      grants += int'(g);
      if (!dma_req || grants == MB) begin refDma = 0; grants = 0; waited = 0; end
    end else if (dma_req && cpu_req) begin
      waited++;
      if (waited == SL) begin refDma = 1; waited = 0; grants = 0; end
    end else waited = 0;
    lastStall = st;
    lastGnt = g;
    #1;
  endtask
  task automatic setCpu(bit r, bit w, logic [31:0] a, logic [31:0] d);
    cpu_req = r; cpu_we = w; cpu_addr = a; cpu_wdata = d;
  endtask
  task automatic setDma(bit r, bit w, logic [31:0] a, logic [31:0] d);
    dma_req = r; dma_we = w; dma_addr = a; dma_wdata = d;
  endtask
  initial begin
    modelReset();
    setCpu(1, 1, 32'h10, 32'h55); setDma(1, 1, 32'h11, 32'h66);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_dma_gnt", 32'(dma_gnt), 0);
    chk("rst_cpu_stall", 32'(cpu_stall), 0);
    chk("rst_dma_pri", 32'(dma_pri), 0);
    chk("rst_dma_rvalid", 32'(dma_rvalid), 0);
    chk("rst_dma_rdata", dma_rdata, 0);
    rst_n = 1; setCpu(0, 0, 0, 0); setDma(0, 0, 0, 0);
    @(posedge clk); #1;
    setCpu(1, 1, 32'h10, 32'h1234);
    cycle();
    setCpu(1, 1, 32'h20, 32'hABCD);
    cycle();
    setCpu(0, 0, 32'h0, 32'h0); setDma(1, 0, 32'h20, 32'h0);
    cycle();
    chk("dma_rd_valid", 32'(dma_rvalid), 1);
    chk("dma_rd_data", dma_rdata, 32'hABCD);
    setDma(0, 0, 0, 0);
    cycle();
    stallSum = 0;
    setCpu(1, 0, 32'h10, 32'h0); setDma(1, 1, 32'h30, 32'hBEEF);
    repeat (SL + MB + 1) cycle();
    chk("burst_stalls", 32'(stallSum), MB);
    chk("burst_mem30", tbMem[8'h30], 32'hBEEF);
    setDma(0, 0, 0, 0); cycle(); cycle();
    setDma(1, 0, 32'h40, 32'h0);
    repeat (SL + 3) cycle();
    setDma(0, 0, 0, 0);
    cycle();
    cycle();
    stallSum = 0;
    setDma(1, 0, 32'h10, 32'h0);
    for (int i = 0; i < 8; i++) begin
      cpu_req = (i % 2) == 0;
      cycle();
      if (lastGnt) setDma(1, 0, 32'(8'h10 + i), 32'h0);
    end
    chk("alt_no_stall", 32'(stallSum), 0);
    chk("alt_not_pri", 32'(dma_pri), 0);
    setCpu(1, 0, 32'h50, 32'h0); setDma(1, 1, 32'h51, 32'hDEAD);
    repeat (SL + 1) cycle();
    #2 rst_n = 0;
    #1;
    chk("midrst_mem_we", 32'(mem_we), 0);
    chk("midrst_dma_pri", 32'(dma_pri), 0);
    chk("midrst_dma_rvalid", 32'(dma_rvalid), 0);
    chk("midrst_dma_gnt", 32'(dma_gnt), 0);
    @(posedge clk); @(negedge clk);
    rst_n = 1; modelReset(); setCpu(0, 0, 0, 0); setDma(0, 0, 0, 0);
    @(posedge clk); #1;
    for (int n = 0; n < 3000; n++) begin
      if (!lastStall)
        setCpu($urandom_range(0, 2) != 0, 1'($urandom), 32'($urandom_range(0, 255)), $urandom);
      if (!(dma_req && !lastGnt))
        setDma($urandom_range(0, 7) != 0, 1'($urandom), 32'($urandom_range(0, 255)), $urandom);
      cycle();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
